// File: rtl/spawn_pkg.sv
// spawn_pkg
// Shared types and helpers for the sprite spawn schedulers.
//   sched_state_t : per-frame scheduler FSM encoding
//   RAND_W        : width of the random word from the random generator
//   popcount()    : number of set bits in an up-to-8-bit vector
package spawn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        ARB,
        ISSUE
    } sched_state_t;

    localparam int RAND_W = 20;

    function automatic int popcount(input logic [7:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin picker: selects the first requesting lane at or
// after ptr, wrapping modulo N.
// Ports:
//   req       in  N   request vector
//   ptr       in  PW  lane where the search starts (must be < N)
//   grant     out N   one-hot of the selected lane, zero if none requests
//   grant_idx out PW  index of the selected lane (0 when none)
//   grant_any out 1   at least one lane requested
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          grant_any
);

    function automatic int wrap_idx(input int p, input int k);
        return (p + k) % N;
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!grant_any && req[wrap_idx(int'(ptr), k)]) begin
                grant_any                      = 1'b1;
                grant[wrap_idx(int'(ptr), k)]  = 1'b1;
                grant_idx                      = PW'(wrap_idx(int'(ptr), k));
            end
        end
    end

endmodule

// File: rtl/spawn_scheduler.sv
// spawn_scheduler
// Per-frame arbiter deciding which spawn lane may launch a new sprite.
// Samples the random word once per frame, filters lanes by cooldown,
// lane-busy and a global active-sprite cap, and issues at most one one-hot
// spawn enable per frame, round-robin fair, held until the next issue.
// Optional build macro SPAWN_SCHED_STATS_EN adds grant/deny counters.
// Ports:
//   clk          in  1          system clock
//   rst_n        in  1          asynchronous active-low reset
//   frame_tick   in  1          one-cycle pulse per frame
//   enable       in  1          gameplay active; no grants when low
//   rand_in      in  RAND_W     random word
//   slot_active  in  NUM_LANES  busy flags from the spawn instances
//   spawn_en     out NUM_LANES  one-hot or zero, held between issues
//   grant_valid  out 1          spawn_en is nonzero
//   overrun      out 1          sticky: frame_tick seen outside IDLE
//   grant_count  out 16         (SPAWN_SCHED_STATS_EN) grants issued
//   deny_count   out 16         (SPAWN_SCHED_STATS_EN) frames with requests but no grant
//
// state  | meaning
// IDLE   | wait for frame_tick; age cooldowns once per accepted tick
// SAMPLE | register per-lane requests from rand_in
// ARB    | filter requests, register round-robin pick
// ISSUE  | drive spawn_en, load cooldown, advance pointer
module spawn_scheduler
    import spawn_pkg::*;
#(
    parameter int NUM_LANES  = 3,
    parameter int REQ_BITS   = 3,
    parameter int COOLDOWN   = 8,
    parameter int MAX_ACTIVE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 enable,
    input  logic [RAND_W-1:0]    rand_in,
    input  logic [NUM_LANES-1:0] slot_active,
    output logic [NUM_LANES-1:0] spawn_en,
    output logic                 grant_valid,
    output logic                 overrun
`ifdef SPAWN_SCHED_STATS_EN
    ,
    output logic [15:0]          grant_count,
    output logic [15:0]          deny_count
`endif
);

    localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int USED_W = NUM_LANES * REQ_BITS;

    if (USED_W > RAND_W) begin : g_width_err
        $error("spawn_scheduler: NUM_LANES*REQ_BITS exceeds rand_in width");
    end

    sched_state_t         state;
    logic [NUM_LANES-1:0] req_q;
    logic [NUM_LANES-1:0] pick_q;
    logic [PW-1:0]        pick_idx_q;
    logic                 pick_any_q;
    logic [PW-1:0]        rr_ptr;
    logic [7:0]           cool [NUM_LANES];

    logic [NUM_LANES-1:0] req_now;
    logic [NUM_LANES-1:0] elig;
    logic [NUM_LANES-1:0] arb_grant;
    logic [PW-1:0]        arb_idx;
    logic                 arb_any;
    logic                 cap_ok;
    logic [PW-1:0]        ptr_next;

    assign cap_ok = popcount(8'(slot_active)) < MAX_ACTIVE;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign req_now[i] = &rand_in[i*REQ_BITS +: REQ_BITS];
        assign elig[i]    = req_q[i] & ~slot_active[i] & (cool[i] == 8'd0)
                            & enable & cap_ok;
    end

    if (USED_W < RAND_W) begin : g_spare_bits
        logic unused_rand;
        assign unused_rand = ^rand_in[RAND_W-1:USED_W];
    end

    rr_arbiter #(
        .N  (NUM_LANES),
        .PW (PW)
    ) u_rr (
        .req       (elig),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    assign ptr_next = (pick_idx_q == PW'(NUM_LANES - 1)) ? '0 : pick_idx_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            spawn_en    <= '0;
            grant_valid <= 1'b0;
            overrun     <= 1'b0;
            rr_ptr      <= '0;
            req_q       <= '0;
            pick_q      <= '0;
            pick_idx_q  <= '0;
            pick_any_q  <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                cool[i] <= 8'd0;
            end
`ifdef SPAWN_SCHED_STATS_EN
            grant_count <= 16'd0;
            deny_count  <= 16'd0;
`endif
        end else begin
            // A tick that lands mid-frame is dropped; only the flag records it.
            if (frame_tick && state != IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            if (cool[i] != 8'd0) begin
                                cool[i] <= cool[i] - 8'd1;
                            end
                        end
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    req_q <= req_now;
                    state <= ARB;
                end
                ARB: begin
                    pick_q     <= arb_grant;
                    pick_idx_q <= arb_idx;
                    pick_any_q <= arb_any;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    spawn_en    <= pick_q;
                    grant_valid <= pick_any_q;
                    if (pick_any_q) begin
                        cool[pick_idx_q] <= 8'(COOLDOWN);
                        rr_ptr           <= ptr_next;
                    end
`ifdef SPAWN_SCHED_STATS_EN
                    if (pick_any_q) begin
                        grant_count <= grant_count + 16'd1;
                    end else if (|req_q) begin
                        deny_count <= deny_count + 16'd1;
                    end
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spawn_scheduler.sv
module tb_spawn_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        enable = 1'b0;
    logic [19:0] rand_in = 20'h0;
    logic [2:0]  slot_active = 3'b000;
    logic [2:0]  spawn_en;
    logic        grant_valid;
    logic        overrun;
`ifdef SPAWN_SCHED_STATS_EN
    logic [15:0] grant_count;
    logic [15:0] deny_count;
`endif

    spawn_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .enable      (enable),
        .rand_in     (rand_in),
        .slot_active (slot_active),
        .spawn_en    (spawn_en),
        .grant_valid (grant_valid),
        .overrun     (overrun)
`ifdef SPAWN_SCHED_STATS_EN
        ,
        .grant_count (grant_count),
        .deny_count  (deny_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       due;
        logic [2:0] en;
        logic     gv;
        logic     ovr;
        string    name;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] last_en  = 3'b000;
    logic       last_ovr = 1'b0;
    int exp_grants = 0;
    int exp_denies = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic req_any(input logic [19:0] r);
        logic [19:0] t;
        t = r;
        return (&t[2:0]) | (&t[5:3]) | (&t[8:6]);
    endfunction

    // Monitor: compares outputs against the scoreboard entry due on this edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.due < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s: checked at cycle %0d expected cycle %0d", e.name, cyc, e.due);
                end else begin
                    chk({e.name, ".spawn_en"}, 16'(spawn_en), 16'(e.en));
                    chk({e.name, ".grant_valid"}, 16'(grant_valid), 16'(e.gv));
                    chk({e.name, ".overrun"}, 16'(overrun), 16'(e.ovr));
                end
            end
        end
    end

    // One frame: tick sampled on edge n+1, spawn_en must change on edge n+4
    // and hold its previous value through edge n+3.
    task automatic frame(input string name, input logic [19:0] r, input logic en,
                         input logic [2:0] act, input logic dbl, input logic [2:0] exp_en);
        int   n;
        logic ovr_now;
        exp_t e;
        @(negedge clk);
        rand_in     = r;
        enable      = en;
        slot_active = act;
        frame_tick  = 1'b1;
        n           = cyc;
        ovr_now     = last_ovr | dbl;
        e.due = n + 3; e.en = last_en; e.gv = |last_en; e.ovr = ovr_now; e.name = {name, "_hold"};
        sb.push_back(e);
        e.due = n + 4; e.en = exp_en; e.gv = |exp_en; e.ovr = ovr_now; e.name = name;
        sb.push_back(e);
        if (dbl) @(negedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
        while (cyc < n + 5) @(negedge clk);
        last_en  = exp_en;
        last_ovr = ovr_now;
        if (exp_en != 3'b000) exp_grants++;
        else if (req_any(r)) exp_denies++;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin : stim
        #1;
        chk("reset.spawn_en", 16'(spawn_en), 16'h0);
        chk("reset.grant_valid", 16'(grant_valid), 16'h0);
        chk("reset.overrun", 16'(overrun), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        frame("f1_lane0",        20'h001FF, 1'b1, 3'b000, 1'b0, 3'b001);
        frame("f2_lane1",        20'h001FF, 1'b1, 3'b000, 1'b0, 3'b010);
        frame("f3_lane2",        20'h001FF, 1'b1, 3'b000, 1'b0, 3'b100);
        frame("f4_all_cooling",  20'h001FF, 1'b1, 3'b000, 1'b0, 3'b000);
        for (int k = 0; k < 3; k++)
            frame("f5_disabled", 20'hFFFFF, 1'b0, 3'b000, 1'b0, 3'b000);
        frame("f8_lane0_cool1",  20'h00007, 1'b1, 3'b000, 1'b0, 3'b000);
        frame("f9_lane0_cool0",  20'h00007, 1'b1, 3'b000, 1'b0, 3'b001);
        frame("f10_disabled",    20'hFFFFF, 1'b0, 3'b000, 1'b0, 3'b000);
        frame("f11_active_cap",  20'hFFFFF, 1'b1, 3'b011, 1'b0, 3'b000);
        frame("f12_busy_skip",   20'hFFFFF, 1'b1, 3'b001, 1'b0, 3'b010);
        frame("f13_lane2_wrap",  20'h001C0, 1'b1, 3'b000, 1'b0, 3'b100);

        // Reset during ARB of a frame; spawn_en is 100 before it.
        @(negedge clk);
        rand_in = 20'h001FF; enable = 1'b1; slot_active = 3'b000; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async.spawn_en", 16'(spawn_en), 16'h0);
        chk("rst_async.grant_valid", 16'(grant_valid), 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_release.spawn_en", 16'(spawn_en), 16'h0);
        chk("rst_release.overrun", 16'(overrun), 16'h0);
        last_en = 3'b000; last_ovr = 1'b0; exp_grants = 0; exp_denies = 0;

        frame("r1_lane0_cool_cleared", 20'h001FF, 1'b1, 3'b000, 1'b0, 3'b001);
        frame("r2_double_tick",        20'h001FF, 1'b1, 3'b000, 1'b1, 3'b010);
        for (int k = 0; k < 5; k++)
            frame("r3_disabled",       20'hFFFFF, 1'b0, 3'b000, 1'b0, 3'b000);
        frame("r8_single_decrement",   20'h00007, 1'b1, 3'b000, 1'b0, 3'b000);
        frame("r9_lane2_from_ptr2",    20'h001C7, 1'b1, 3'b000, 1'b0, 3'b100);
        frame("r10_ptr_wrapped",       20'h001FF, 1'b1, 3'b000, 1'b0, 3'b001);

`ifdef SPAWN_SCHED_STATS_EN
        chk("stats.grant_count", grant_count, 16'(exp_grants));
        chk("stats.deny_count", deny_count, 16'(exp_denies));
`endif

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spawn_scheduler.md
Name: spawn_scheduler

Overview:
- Per-frame arbiter that decides which spawn lane may launch a new sprite, replacing the ad-hoc random-bit AND gating at the top level.
- Samples the random generator once per frame and filters lanes by cooldown, lane-busy and a global cap on concurrent sprites.
- Issues at most one one-hot spawn enable per frame, round-robin fair, held stable for the whole frame so VGA_VS-clocked spawn instances see a clean level.

Parameters:
- NUM_LANES, 3, number of spawn lanes; legal range 1..6.
- REQ_BITS, 3, random bits per lane; a lane requests when all its bits are 1 (probability 1/8 at default).
- COOLDOWN, 8, frames a lane is blocked after being granted; legal range 1..255.
- MAX_ACTIVE, 2, maximum number of simultaneously active lanes before new grants are refused.

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  single-cycle pulse, once per frame (VGA_VS rising edge synchronised into clk).
- enable  in  1  gameplay active (PLY_0); when low, no grants are issued.
- rand_in  in  20  random word from the random generator.
- slot_active  in  NUM_LANES  active flags from the spawn instances.
- spawn_en  out  NUM_LANES  one-hot or zero; level held from one issue to the next.
- grant_valid  out  1  1 when spawn_en is nonzero.
- overrun  out  1  sticky; set when frame_tick arrives outside IDLE. Cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, spawn_en=0, grant_valid=0, overrun=0, rr_ptr=0, all cooldowns=0, sampled request register=0.
- FSM states: IDLE, SAMPLE, ARB, ISSUE.
  - IDLE: on frame_tick go to SAMPLE. Every cooldown counter that is nonzero decrements by 1, saturating at 0. Decrement happens regardless of enable.
  - SAMPLE: req[i] = &rand_in[i*REQ_BITS +: REQ_BITS], registered. Go to ARB.
  - ARB: elig[i] = req[i] & ~slot_active[i] & (cool[i]==0) & enable & (popcount(slot_active) < MAX_ACTIVE). Round-robin pick of the first eligible lane at or after rr_ptr, wrapping modulo NUM_LANES; the result is registered. Go to ISSUE.
  - ISSUE: spawn_en <= one-hot of the pick, or 0 if none is eligible. grant_valid follows. On a grant: cool[pick] <= COOLDOWN and rr_ptr <= (pick+1) mod NUM_LANES; otherwise rr_ptr is unchanged. Go to IDLE.
- Latency: a frame_tick in cycle T updates spawn_en in cycle T+3. spawn_en is otherwise unchanged between ISSUE cycles.
- The cooldown load in ISSUE wins over the IDLE decrement; the two cannot coincide.
- frame_tick while not in IDLE is dropped: no decrement, overrun<=1, and the FSM continues unaffected.
- slot_active and enable are sampled in ARB only. Changes in any other cycle have no effect on the current frame.
- rr_ptr wrap: pointer NUM_LANES-1 followed by a grant on lane NUM_LANES-1 gives 0.
- Reset mid-operation: immediately returns to the reset values. Any in-flight grant is discarded.
- NUM_LANES*REQ_BITS > 20 is an elaboration error ($error).

Optional Feature:
- Macro SPAWN_SCHED_STATS_EN.
- Defined: adds outputs grant_count[15:0] (grants issued) and deny_count[15:0] (ISSUE cycles with any req set but no grant). Both wrap at 16 bits and reset to 0.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package spawn_pkg holds:
  - typedef enum {IDLE, SAMPLE, ARB, ISSUE} sched_state_t;
  - localparam RAND_W=20;
  - a popcount function shared with future schedulers.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs a one-hot grant and a grant index. Purely combinational; the registered pick lives in spawn_scheduler.

Test Plan:
- Reset then enable=1, slot_active=0, rand_in=20'h001FF, frame_tick at T: spawn_en=3'b001 at T+3; rr_ptr=1; cool[0]=8.
- Same rand_in on the next frame: lane 1 granted (3'b010). On the frame after: 3'b100. On the following frame, lane 0 is still cooling, so the pick is lane 1 only if its cooldown has expired; otherwise spawn_en=0.
- slot_active=3'b011 (count 2 = MAX_ACTIVE), rand_in all ones: spawn_en=0 and grant_valid=0 at T+3; deny_count increments under SPAWN_SCHED_STATS_EN.
- enable=0, rand_in=20'hFFFFF: spawn_en=0 for 10 frames; cooldowns still decrement (grant lane 0 with enable=1, wait 8 frames with enable=0, then lane 0 is eligible again).
- frame_tick pulses at T and T+1: overrun=1 and stays 1; only one decrement applied; spawn_en is valid at T+3.
- rst_n low in the ARB cycle with a pending grant: spawn_en=0 immediately (asynchronous); after release, the FSM is in IDLE with all cooldowns 0.
